// File: rtl/game_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_sequencer_if
// Purpose : groups the button/coordinate/map inputs and the game status outputs
//           of the battleship game sequencer into one bundle.
// Signals :
//   start, confirmMap, confirmAttack  debounced level buttons (master -> slave)
//   x_coord_code, y_coord_code        attack column / row     (master -> slave)
//   selectedMap                       map from map_decoder     (master -> slave)
//   game_state_code                   00 IDLE 01 PREP 10 ATTACK 11 END
//   enablePreparation, enableAttack   phase enables
//   ship_map, hit_map, miss_map       latched map and attack results
//   attacks_left                      remaining attacks
//   ledRgb                            last attack result 00/01/10/11
//   game_over, won                    end-of-game status
// Modports: master drives the inputs of the sequencer, slave is the sequencer.
// -----------------------------------------------------------------------------
interface game_sequencer_if #(
    parameter int M_DATA_WIDTH = 35,
    parameter int ATK_WIDTH    = 4
);
    logic                    start;
    logic                    confirmMap;
    logic                    confirmAttack;
    logic [2:0]              x_coord_code;
    logic [2:0]              y_coord_code;
    logic [M_DATA_WIDTH-1:0] selectedMap;
    logic [1:0]              game_state_code;
    logic                    enablePreparation;
    logic                    enableAttack;
    logic [M_DATA_WIDTH-1:0] ship_map;
    logic [M_DATA_WIDTH-1:0] hit_map;
    logic [M_DATA_WIDTH-1:0] miss_map;
    logic [ATK_WIDTH-1:0]    attacks_left;
    logic [1:0]              ledRgb;
    logic                    game_over;
    logic                    won;

    modport master (
        output start, confirmMap, confirmAttack, x_coord_code, y_coord_code, selectedMap,
        input  game_state_code, enablePreparation, enableAttack, ship_map, hit_map,
               miss_map, attacks_left, ledRgb, game_over, won
    );

    modport slave (
        input  start, confirmMap, confirmAttack, x_coord_code, y_coord_code, selectedMap,
        output game_state_code, enablePreparation, enableAttack, ship_map, hit_map,
               miss_map, attacks_left, ledRgb, game_over, won
    );
endinterface

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Purpose : central controller of the battleship game. Walks IDLE -> PREP ->
//           ATTACK -> END, latches the chosen ship map, scores each attack
//           against it and declares win or loss. All outputs are registered.
// Ports   :
//   clk    system clock (divided clock)
//   reset  synchronous, active-high reset
//   bus    game_sequencer_if.slave (buttons, coordinates, map in; status out)
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int M_COLUNE_SIZE   = 7,
    parameter int M_TOTAL_COLUNES = 5,
    parameter int M_DATA_WIDTH    = 35,
    parameter int MAX_ATTACKS     = 12,
    parameter int ATK_WIDTH       = 4
) (
    input  logic                clk,
    input  logic                reset,
    game_sequencer_if.slave     bus
);
    localparam int IDX_W = $clog2(M_DATA_WIDTH);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_PREP   = 2'b01;
    localparam logic [1:0] ST_ATTACK = 2'b10;
    localparam logic [1:0] ST_END    = 2'b11;

    localparam logic [1:0] LED_NONE = 2'b00;
    localparam logic [1:0] LED_HIT  = 2'b01;
    localparam logic [1:0] LED_MISS = 2'b10;
    localparam logic [1:0] LED_REJ  = 2'b11;

    localparam logic [2:0]              X_LIM    = 3'(M_TOTAL_COLUNES);
    localparam logic [2:0]              Y_LIM    = 3'(M_COLUNE_SIZE);
    localparam logic [ATK_WIDTH-1:0]    ATK_FULL = ATK_WIDTH'(MAX_ATTACKS);
    localparam logic [ATK_WIDTH-1:0]    ATK_ZERO = {ATK_WIDTH{1'b0}};
    localparam logic [M_DATA_WIDTH-1:0] MAP_ZERO = {M_DATA_WIDTH{1'b0}};
    localparam logic [M_DATA_WIDTH-1:0] MAP_ONE  = {{(M_DATA_WIDTH-1){1'b0}}, 1'b1};

    // Column-major cell numbering: each column holds M_COLUNE_SIZE rows.
    function automatic logic [IDX_W-1:0] cell_index(input logic [2:0] x, input logic [2:0] y);
        cell_index = IDX_W'(x) * IDX_W'(M_COLUNE_SIZE) + IDX_W'(y);
    endfunction

    logic [1:0]              r_state;
    logic                    r_start_d, r_cmap_d, r_catk_d;
    logic [M_DATA_WIDTH-1:0] r_ship, r_hit, r_miss;
    logic [ATK_WIDTH-1:0]    r_atk;
    logic [1:0]              r_led;
    logic                    r_won, r_game_over, r_en_prep, r_en_atk;

    logic [1:0]              w_state_nxt;
    logic [M_DATA_WIDTH-1:0] w_ship_nxt, w_hit_nxt, w_miss_nxt, w_cell;
    logic [ATK_WIDTH-1:0]    w_atk_nxt;
    logic [1:0]              w_led_nxt;
    logic                    w_won_nxt;
    logic                    w_start_edge, w_cmap_edge, w_catk_edge;
    logic                    w_valid, w_used, w_accept, w_is_ship;
    logic [IDX_W-1:0]        w_idx;

    assign w_start_edge = bus.start         & ~r_start_d;
    assign w_cmap_edge  = bus.confirmMap    & ~r_cmap_d;
    assign w_catk_edge  = bus.confirmAttack & ~r_catk_d;

    // The cell mask is only meaningful when the coordinate is valid.
    assign w_valid   = (bus.x_coord_code < X_LIM) && (bus.y_coord_code < Y_LIM);
    assign w_idx     = cell_index(bus.x_coord_code, bus.y_coord_code);
    assign w_cell    = w_valid ? (MAP_ONE << w_idx) : MAP_ZERO;
    assign w_used    = ((r_hit | r_miss) & w_cell) != MAP_ZERO;
    assign w_is_ship = (r_ship & w_cell) != MAP_ZERO;
    assign w_accept  = w_catk_edge && w_valid && !w_used;

    // Button history; preset to 1 so a button held through reset gives no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_d <= 1'b1;
            r_cmap_d  <= 1'b1;
            r_catk_d  <= 1'b1;
        end else begin
            r_start_d <= bus.start;
            r_cmap_d  <= bus.confirmMap;
            r_catk_d  <= bus.confirmAttack;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the win/loss decision looks at the post-attack maps.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_edge) w_state_nxt = ST_PREP; else w_state_nxt = ST_IDLE;
            ST_PREP:   if (w_cmap_edge && (bus.selectedMap != MAP_ZERO)) w_state_nxt = ST_ATTACK;
                       else w_state_nxt = ST_PREP;
            ST_ATTACK: if (w_accept && ((w_hit_nxt == r_ship) || (w_atk_nxt == ATK_ZERO)))
                           w_state_nxt = ST_END;
                       else w_state_nxt = ST_ATTACK;
            ST_END:    if (w_start_edge) w_state_nxt = ST_IDLE; else w_state_nxt = ST_END;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values: map latching, attack scoring, result LED.
    always_comb begin
        w_ship_nxt = r_ship;
        w_hit_nxt  = r_hit;
        w_miss_nxt = r_miss;
        w_atk_nxt  = r_atk;
        w_led_nxt  = r_led;
        w_won_nxt  = r_won;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_hit_nxt  = MAP_ZERO;
                    w_miss_nxt = MAP_ZERO;
                    w_atk_nxt  = ATK_FULL;
                    w_led_nxt  = LED_NONE;
                    w_won_nxt  = 1'b0;
                end else begin
                    w_led_nxt  = r_led;
                end
            end
            ST_PREP: begin
                if (w_cmap_edge && (bus.selectedMap != MAP_ZERO)) begin
                    w_ship_nxt = bus.selectedMap;
                end else if (w_cmap_edge) begin
                    w_led_nxt  = LED_REJ;
                end else begin
                    w_ship_nxt = r_ship;
                end
            end
            ST_ATTACK: begin
                if (w_catk_edge && !w_accept) begin
                    w_led_nxt = LED_REJ;
                end else if (w_accept) begin
                    if (w_is_ship) begin
                        w_hit_nxt  = r_hit | w_cell;
                        w_led_nxt  = LED_HIT;
                    end else begin
                        w_miss_nxt = r_miss | w_cell;
                        w_led_nxt  = LED_MISS;
                    end
                    // Counter saturates at zero.
                    if (r_atk != ATK_ZERO) w_atk_nxt = r_atk - ATK_WIDTH'(1);
                    else w_atk_nxt = ATK_ZERO;
                    // A full hit_map wins even if this was the last attack.
                    if (w_hit_nxt == r_ship) w_won_nxt = 1'b1;
                    else w_won_nxt = 1'b0;
                end else begin
                    w_led_nxt = r_led;
                end
            end
            ST_END:  w_led_nxt = r_led;
            default: w_led_nxt = LED_NONE;
        endcase
    end

    // Registered datapath and state-decoded outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ship      <= MAP_ZERO;
            r_hit       <= MAP_ZERO;
            r_miss      <= MAP_ZERO;
            r_atk       <= ATK_FULL;
            r_led       <= LED_NONE;
            r_won       <= 1'b0;
            r_game_over <= 1'b0;
            r_en_prep   <= 1'b0;
            r_en_atk    <= 1'b0;
        end else begin
            r_ship      <= w_ship_nxt;
            r_hit       <= w_hit_nxt;
            r_miss      <= w_miss_nxt;
            r_atk       <= w_atk_nxt;
            r_led       <= w_led_nxt;
            r_won       <= w_won_nxt;
            r_game_over <= (w_state_nxt == ST_END);
            r_en_prep   <= (w_state_nxt == ST_PREP);
            r_en_atk    <= (w_state_nxt == ST_ATTACK);
        end
    end

    assign bus.game_state_code   = r_state;
    assign bus.enablePreparation = r_en_prep;
    assign bus.enableAttack      = r_en_atk;
    assign bus.ship_map          = r_ship;
    assign bus.hit_map           = r_hit;
    assign bus.miss_map          = r_miss;
    assign bus.attacks_left      = r_atk;
    assign bus.ledRgb            = r_led;
    assign bus.game_over         = r_game_over;
    assign bus.won               = r_won;
endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Purpose : self-checking bench for game_sequencer. A behavioural game model
//           predicts every output after each driven cycle; predictions go to a
//           scoreboard queue and are compared once the DUT has clocked.
// -----------------------------------------------------------------------------
module tb_game_sequencer;
    localparam int DW = 35;
    localparam int AW = 4;

    typedef struct {
        logic [1:0]    st;
        logic [DW-1:0] ship;
        logic [DW-1:0] hit;
        logic [DW-1:0] miss;
        logic [AW-1:0] atk;
        logic [1:0]    led;
        logic          won;
    } snap_t;

    logic clk;
    logic reset;
    int   chk_cnt;
    int   err_cnt;
    snap_t sb_q[$];

    // Reference model state.
    logic [1:0]    m_state;
    logic [DW-1:0] m_ship, m_hit, m_miss;
    int            m_atk;
    logic [1:0]    m_led;
    logic          m_won;

    game_sequencer_if #(.M_DATA_WIDTH(DW), .ATK_WIDTH(AW)) bus ();

    game_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run gets stuck.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 2'b00; m_ship = '0; m_hit = '0; m_miss = '0;
        m_atk = 12; m_led = 2'b00; m_won = 1'b0;
    endtask

    task automatic push_expect();
        snap_t s;
        s.st = m_state; s.ship = m_ship; s.hit = m_hit; s.miss = m_miss;
        s.atk = AW'(m_atk); s.led = m_led; s.won = m_won;
        sb_q.push_back(s);
    endtask

    task automatic compare_outputs(input string tag);
        snap_t e;
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_value({tag, "_state"}, 64'(bus.game_state_code), 64'(e.st));
            check_value({tag, "_enprep"}, 64'(bus.enablePreparation), 64'(e.st == 2'b01));
            check_value({tag, "_enatk"}, 64'(bus.enableAttack), 64'(e.st == 2'b10));
            check_value({tag, "_ship"}, 64'(bus.ship_map), 64'(e.ship));
            check_value({tag, "_hit"}, 64'(bus.hit_map), 64'(e.hit));
            check_value({tag, "_miss"}, 64'(bus.miss_map), 64'(e.miss));
            check_value({tag, "_atk"}, 64'(bus.attacks_left), 64'(e.atk));
            check_value({tag, "_led"}, 64'(bus.ledRgb), 64'(e.led));
            check_value({tag, "_over"}, 64'(bus.game_over), 64'(e.st == 2'b11));
            check_value({tag, "_won"}, 64'(bus.won), 64'(e.won));
        end
    endtask

    // Inputs are set at a falling edge; results are read at the next one.
    task automatic step(input string tag);
        push_expect();
        @(posedge clk);
        @(negedge clk);
        compare_outputs(tag);
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        if (m_state == 2'b00) begin
            m_state = 2'b01; m_hit = '0; m_miss = '0; m_atk = 12; m_led = 2'b00; m_won = 1'b0;
        end else if (m_state == 2'b11) begin
            m_state = 2'b00;
        end
        step("start_hi");
        bus.start = 1'b0;
        step("start_lo");
    endtask

    task automatic press_map(input logic [DW-1:0] map);
        bus.selectedMap = map;
        bus.confirmMap  = 1'b1;
        if (m_state == 2'b01) begin
            if (map != '0) begin
                m_ship = map; m_state = 2'b10;
            end else begin
                m_led = 2'b11;
            end
        end
        step("map_hi");
        bus.confirmMap = 1'b0;
        step("map_lo");
    endtask

    task automatic model_attack(input int x, input int y);
        int idx;
        if (m_state == 2'b10) begin
            idx = x * 7 + y;
            if (x >= 5 || y >= 7) begin
                m_led = 2'b11;
            end else if (m_hit[idx] || m_miss[idx]) begin
                m_led = 2'b11;
            end else begin
                if (m_ship[idx]) begin
                    m_hit[idx] = 1'b1; m_led = 2'b01;
                end else begin
                    m_miss[idx] = 1'b1; m_led = 2'b10;
                end
                if (m_atk > 0) m_atk--;
                if (m_hit == m_ship) begin
                    m_state = 2'b11; m_won = 1'b1;
                end else if (m_atk == 0) begin
                    m_state = 2'b11; m_won = 1'b0;
                end
            end
        end
    endtask

    task automatic press_attack(input int x, input int y);
        bus.x_coord_code  = 3'(x);
        bus.y_coord_code  = 3'(y);
        bus.confirmAttack = 1'b1;
        model_attack(x, y);
        step("atk_hi");
        bus.confirmAttack = 1'b0;
        step("atk_lo");
    endtask

    initial begin
        chk_cnt = 0;
        err_cnt = 0;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.confirmMap = 1'b0;
        bus.confirmAttack = 1'b0;
        bus.x_coord_code = 3'd0;
        bus.y_coord_code = 3'd0;
        bus.selectedMap = '0;
        model_reset();
        step("reset");
        step("reset");

        // start held through reset release must not count as an edge.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step("start_held");
        bus.start = 1'b0;
        step("start_rel");

        press_start();
        press_map(35'h0);
        check_value("prep_rej_led", 64'(bus.ledRgb), 64'h3);
        press_map(35'h3);
        check_value("ship_latched", 64'(bus.ship_map), 64'h3);

        press_attack(0, 0);
        check_value("first_hit_map", 64'(bus.hit_map), 64'h1);
        check_value("first_hit_atk", 64'(bus.attacks_left), 64'd11);
        press_attack(0, 0);
        press_attack(5, 2);
        check_value("invalid_atk", 64'(bus.attacks_left), 64'd11);
        press_attack(0, 1);
        check_value("win_state", 64'(bus.game_state_code), 64'h3);
        check_value("win_flag", 64'(bus.won), 64'h1);
        press_attack(0, 2);
        press_map(35'h7);

        // Second game: exhaust all attacks on empty cells.
        press_start();
        press_start();
        press_map(35'h3);
        for (int i = 0; i < 12; i++) press_attack(1 + i / 7, i % 7);
        check_value("loss_miss_cnt", 64'($countones(bus.miss_map)), 64'd12);
        check_value("loss_atk", 64'(bus.attacks_left), 64'd0);
        check_value("loss_won", 64'(bus.won), 64'd0);

        // Third game: reset lands together with an attack edge.
        press_start();
        press_start();
        press_map(35'h3);
        bus.x_coord_code = 3'd1;
        bus.y_coord_code = 3'd0;
        bus.confirmAttack = 1'b1;
        reset = 1'b1;
        model_reset();
        step("rst_mid");
        check_value("rst_mid_atk", 64'(bus.attacks_left), 64'd12);
        reset = 1'b0;
        step("rst_after");
        bus.confirmAttack = 1'b0;
        step("rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central controller for the battleship game. Sequences the game through idle, preparation, attack and end phases, and latches the ship map chosen in preparation.
- Validates and scores each attack against the latched map, tracks hits, misses and remaining attacks, and declares win or loss.
- Its game_state_code and enables drive the matrix image mux, both displayers and the full display decoder, replacing the switch-driven game_state_code.

Parameters:
- M_COLUNE_SIZE, 7, rows per matrix column (valid y range 0..6).
- M_TOTAL_COLUNES, 5, matrix columns (valid x range 0..4).
- M_DATA_WIDTH, 35, map width = M_COLUNE_SIZE*M_TOTAL_COLUNES.
- MAX_ATTACKS, 12, attacks allowed per game.
- ATK_WIDTH, 4, width of the attack counter; must hold MAX_ATTACKS.

Ports:
- clk  in  1  system clock (divided clock from freq_div).
- reset  in  1  synchronous, active-high reset.
- start  in  1  debounced level button; rising edge advances IDLE->PREP and END->IDLE.
- confirmMap  in  1  debounced level; rising edge in PREP latches selectedMap.
- confirmAttack  in  1  debounced level; rising edge in ATTACK fires an attack.
- x_coord_code  in  3  attack column.
- y_coord_code  in  3  attack row.
- selectedMap  in  M_DATA_WIDTH  map from map_decoder.
- game_state_code  out  2  00 IDLE, 01 PREP, 10 ATTACK, 11 END.
- enablePreparation  out  1  high only in PREP.
- enableAttack  out  1  high only in ATTACK.
- ship_map  out  M_DATA_WIDTH  latched map.
- hit_map  out  M_DATA_WIDTH  cells attacked and occupied.
- miss_map  out  M_DATA_WIDTH  cells attacked and empty.
- attacks_left  out  ATK_WIDTH  remaining attacks.
- ledRgb  out  2  result of the last attack: 00 none, 01 hit, 10 miss, 11 rejected.
- game_over  out  1  high in END.
- won  out  1  valid in END; 1 means every ship cell was hit.

Behaviour:
- All state is registered on the clk rising edge. All outputs are registered.
- Reset (synchronous, priority over everything, including mid-attack):
  - state IDLE; ship_map, hit_map and miss_map 0.
  - attacks_left = MAX_ATTACKS; ledRgb 00; won 0; game_over 0.
  - Edge-detect registers for start, confirmMap and confirmAttack reset to 1, so a button held through reset produces no edge.
- Edge detection: a rising edge is the current input 1 with the previous sample 0. Each edge is processed exactly once, and only in its own state; edges in other states are discarded.
- Cell index for (x, y) = x*M_COLUNE_SIZE + y.
- An attack coordinate is valid iff x < M_TOTAL_COLUNES and y < M_COLUNE_SIZE.
- IDLE:
  - start edge -> PREP.
  - On that same transition, clear hit_map and miss_map, set attacks_left = MAX_ATTACKS, and clear ledRgb, won and game_over.
- PREP:
  - confirmMap edge with selectedMap != 0 -> latch ship_map, go to ATTACK next cycle.
  - confirmMap edge with selectedMap == 0 -> stay in PREP, ledRgb = 11.
  - start is ignored in PREP.
- ATTACK, on each confirmAttack edge (result is visible the following cycle):
  - Invalid coordinate, or cell already set in hit_map|miss_map -> ledRgb = 11. No counter change, no map change.
  - Valid and ship_map[idx] = 1 -> set hit_map[idx], ledRgb = 01, decrement attacks_left.
  - Valid and ship_map[idx] = 0 -> set miss_map[idx], ledRgb = 10, decrement attacks_left.
  - Win check uses next-state values: if the next hit_map equals ship_map -> END with won = 1. This takes priority when the same attack also consumes the last attack.
  - Else if the next attacks_left = 0 -> END with won = 0.
  - attacks_left never underflows.
- END:
  - game_over = 1; maps, ledRgb and won are frozen.
  - confirmAttack and confirmMap are ignored.
  - start edge -> IDLE.
- Per-state outputs: enablePreparation and enableAttack are decoded from the registered state. game_state_code equals the state encoding.
- One edge per cycle per input is assumed from the debouncers. Simultaneous edges on different inputs are resolved by the current state only.

Test Plan:
- Reset with start held at 1, then hold start for 5 cycles -> state stays IDLE (00), attacks_left = 12, all maps 0.
- start edge; confirmMap edge with selectedMap = 0 -> state 01, ledRgb = 11. Then confirmMap with selectedMap = 0x000000003 -> state 10, ship_map = 0x3.
- Attack (0,0) -> next cycle hit_map = 0x1, ledRgb = 01, attacks_left = 11. Attack (0,0) again -> ledRgb = 11, attacks_left stays 11. Attack (5,2) -> ledRgb = 11, no change.
- Attack (0,1) -> hit_map = 0x3, state 11, won = 1, game_over = 1. A further confirmAttack edge -> no change.
- New game with ship_map = 0x3: 12 attacks on empty cells (1,0)..(1,6),(2,0)..(2,4) -> after the 12th, miss_map has 12 bits set, attacks_left = 0, state 11, won = 0.
- Assert reset in ATTACK right after a confirmAttack edge -> next cycle state 00, maps 0, ledRgb = 00, attacks_left = 12.
